// File: rtl/ext_pkg.sv
// Shared definitions for the immediate extender: opcode encodings.
package ext_pkg;

    typedef logic [2:0] eop_t;

    localparam eop_t EOP_SIGN  = 3'b000;
    localparam eop_t EOP_ZERO  = 3'b001;
    localparam eop_t EOP_UPPER = 3'b010;
    localparam eop_t EOP_SBR   = 3'b011;
    localparam eop_t EOP_ZBR   = 3'b100;

endpackage

// File: rtl/ext_skid.sv
// Generic 2-entry valid/ready buffer. in_ready depends only on registered
// occupancy, so there is no combinational path from out_ready to in_ready.
module ext_skid #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign in_ready  = reset_n & (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Storage, pointers and occupancy; reset clears entries so the head reads zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate extender: combinational extension mux feeding a
// 2-entry skid buffer, plus a sticky illegal-opcode flag.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [2:0]        in_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              err_sticky
);

    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err;
    logic [DATA_W:0]   head;

    assign sext = DATA_W'(signed'(in_imm));
    assign zext = DATA_W'(in_imm);

    // Select the extended operand for the incoming beat; illegal opcodes give zero data.
    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (eop_t'(in_eop))
            EOP_SIGN:  ext_data = sext;
            EOP_ZERO:  ext_data = zext;
            EOP_UPPER: ext_data = zext << (DATA_W - IMM_W);
            EOP_SBR:   ext_data = sext << BR_SHIFT;
            EOP_ZBR:   ext_data = zext << BR_SHIFT;
            default:   ext_err  = 1'b1;
        endcase
    end

    ext_skid #(
        .W(DATA_W + 1)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({ext_data, ext_err}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_data = head[DATA_W:1];
    assign out_err  = head[0];

    // Latch any accepted illegal opcode until reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
        end else if (in_valid && in_ready && ext_err) begin
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: opcode table plus backpressure, streaming,
// mid-operation reset and a narrower-immediate instance.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_eop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic        err_sticky;

    logic        s_valid;
    logic        s_in_ready;
    logic [11:0] s_imm;
    logic [2:0]  s_eop;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic        s_out_err;
    logic        s_err_sticky;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ext_pipe #(.IMM_W(16), .DATA_W(32), .BR_SHIFT(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_imm     (in_imm),
        .in_eop     (in_eop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .err_sticky (err_sticky)
    );

    ext_pipe #(.IMM_W(12), .DATA_W(32), .BR_SHIFT(2)) dut_s (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (s_valid),
        .in_ready   (s_in_ready),
        .in_imm     (s_imm),
        .in_eop     (s_eop),
        .out_valid  (s_out_valid),
        .out_ready  (1'b1),
        .out_data   (s_out_data),
        .out_err    (s_out_err),
        .err_sticky (s_err_sticky)
    );

    typedef struct {
        logic [2:0]  eop;
        logic [15:0] imm;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{3'b000, 16'h8001, 32'hFFFF8001, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 16'h8001, 32'h00008001, 1'b0, 1'b0};
        vecs[2]  = '{3'b010, 16'h8001, 32'h80010000, 1'b0, 1'b0};
        vecs[3]  = '{3'b011, 16'h8001, 32'hFFFE0004, 1'b0, 1'b0};
        vecs[4]  = '{3'b100, 16'h8001, 32'h00020004, 1'b0, 1'b0};
        vecs[5]  = '{3'b000, 16'h7FFF, 32'h00007FFF, 1'b0, 1'b0};
        vecs[6]  = '{3'b010, 16'hFFFF, 32'hFFFF0000, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 16'hFFFF, 32'h0003FFFC, 1'b0, 1'b0};
        vecs[8]  = '{3'b110, 16'h1234, 32'h00000000, 1'b1, 1'b1};
        vecs[9]  = '{3'b011, 16'hFFFF, 32'hFFFFFFFC, 1'b0, 1'b1};
        vecs[10] = '{3'b101, 16'hABCD, 32'h00000000, 1'b1, 1'b1};
        vecs[11] = '{3'b111, 16'h0001, 32'h00000000, 1'b1, 1'b1};

        reset_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_eop = '0; out_ready = 1'b1;
        s_valid = 1'b0; s_imm = '0; s_eop = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Opcode table, one beat at a time
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_imm = vecs[i].imm; in_eop = vecs[i].eop;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_sticky", i), 32'(err_sticky), 32'(vecs[i].exp_sticky));
            @(negedge clk);
            check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Reset clears sticky
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("sticky_cleared", 32'(err_sticky), 32'd0);

        // Backpressure: fill, hold, drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'd1; in_eop = 3'b001;
        @(negedge clk);
        check("bp_ready_after1", 32'(in_ready), 32'd1);
        in_imm = 16'd2;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_ready_full", 32'(in_ready), 32'd0);
        check("bp_head1", out_data, 32'd1);
        @(negedge clk);
        check("bp_head1_held", out_data, 32'd1);
        check("bp_err_held", 32'(out_err), 32'd0);
        check("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_head2", out_data, 32'd2);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Streaming: 8 back-to-back beats
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                check($sformatf("st%0d_valid", i - 1), 32'(out_valid), 32'd1);
                check($sformatf("st%0d_data", i - 1), out_data, 32'(16 + i - 1));
            end
            check($sformatf("st%0d_in_ready", i), 32'(in_ready), 32'd1);
            if (i < 8) begin
                in_valid = 1'b1; in_imm = 16'(16 + i); in_eop = 3'b001;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("st_drained", 32'(out_valid), 32'd0);

        // Reset mid-operation with two entries held
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h0042; in_eop = 3'b111;
        @(negedge clk);
        in_eop = 3'b001;
        @(negedge clk);
        check("mid_full", 32'(in_ready), 32'd0);
        check("mid_sticky", 32'(err_sticky), 32'd1);
        reset_n = 1'b0; in_imm = 16'h0055;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sticky", 32'(err_sticky), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1; in_imm = 16'h00AB; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_first_valid", 32'(out_valid), 32'd1);
        check("mid_first_data", out_data, 32'h000000AB);
        check("mid_first_err", 32'(out_err), 32'd0);
        @(negedge clk);
        check("mid_only_one", 32'(out_valid), 32'd0);

        // Narrow immediate instance
        s_valid = 1'b1; s_imm = 12'hFFF; s_eop = 3'b011;
        @(negedge clk);
        s_valid = 1'b0;
        check("sw_valid", 32'(s_out_valid), 32'd1);
        check("sw_data", s_out_data, 32'hFFFFFFFC);
        check("sw_err", 32'(s_out_err), 32'd0);
        s_valid = 1'b1; s_imm = 12'h800; s_eop = 3'b010;
        @(negedge clk);
        s_valid = 1'b0;
        check("sw_upper", s_out_data, 32'h80000000);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined immediate extender for the datapath. It accepts an IMM_W-bit immediate and a 3-bit extension opcode over a valid/ready handshake. It produces a DATA_W-bit extended operand through a registered 2-entry skid buffer, and flags illegal opcodes. It sits between decode and the ALU-B/branch-target operand mux, replacing the combinational extender when those stages are decoupled.

## Interface
- IMM_W, 16: immediate width; ≥2.
- DATA_W, 32: output width; must satisfy DATA_W ≥ IMM_W + BR_SHIFT.
- BR_SHIFT, 2: left shift for branch-offset modes.
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_imm  in  IMM_W  raw immediate.
- in_eop  in  3  extension opcode.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head this cycle.
- out_data  out  DATA_W  extended operand.
- out_err  out  1  head entry came from an illegal opcode.
- err_sticky  out  1  set once any illegal opcode is accepted; cleared only by reset.

## Operation
- Opcodes:
  - 000 sign-extend.
  - 001 zero-extend.
  - 010 upper: imm placed at [DATA_W-1 : DATA_W-IMM_W], low bits 0.
  - 011 sign-extend then << BR_SHIFT.
  - 100 zero-extend then << BR_SHIFT.
  - 101–111 illegal: data = 0, err bit = 1.
- Extension is combinational on the input beat. The {data, err} pair is written into the buffer on accept (in_valid & in_ready).
- Buffer: 2-entry FIFO, count ∈ {0, 1, 2}, pointers wrap mod 2.
- in_ready = reset_n & (count != 2). It is a function of registered count only, with no combinational path from out_ready.
- out_valid = (count != 0); out_data and out_err show the head entry.
- Pop on out_valid & out_ready. Push and pop in the same cycle leave count unchanged; with count 1, full throughput is sustained.
- count 2: no push is possible; a pop frees a slot, and in_ready rises the next cycle.
- count 0 with out_ready high: nothing pops; the beat accepted this cycle appears next cycle.
- err_sticky is set on the edge that accepts an illegal opcode.

## Timing
- Latency: a beat accepted at edge N is visible on out_* after edge N, 1 cycle.
- Throughput: 1 beat/cycle while out_ready stays high.
- Reset (reset_n low at an edge): count = 0, pointers = 0, out_valid = 0, out_data = 0, out_err = 0, err_sticky = 0. in_ready is 0 while reset_n is low.
- Reset mid-operation discards all buffered entries; no beat is accepted on the reset edge.
- out_data and out_err of a held head entry stay stable while out_valid & !out_ready.

## Structure
- Package ext_pkg: EOP_SIGN, EOP_ZERO, EOP_UPPER, EOP_SBR, EOP_ZBR localparams (3-bit), plus an eop_t typedef.
- Sub-module ext_skid: generic 2-entry valid/ready buffer, parametrised on payload width (DATA_W+1).
- Top ext_pipe: extension mux plus sticky flag only.

## Test plan
- Modes, IMM_W=16, DATA_W=32, imm 16'h8001, out_ready=1, one cycle after accept:
  - 000 → 32'hFFFF8001.
  - 001 → 32'h00008001.
  - 010 → 32'h80010000.
  - 011 → 32'hFFFE0004.
  - 100 → 32'h00020004.
- Illegal: eop 110, imm 16'h1234 → out_data 0, out_err 1, err_sticky 1 and remains 1 through later legal beats until reset.
- Backpressure: out_ready=0, push imm 1 then 2 → in_ready 0 after the second accept. Raise out_ready → outputs 1 then 2 in order, and in_ready returns 1 one cycle after the first pop.
- Streaming: 8 back-to-back beats with out_ready=1 → 8 outputs on consecutive cycles, count never exceeds 1.
- Reset mid-op: count 2, pull reset_n low for 1 cycle → out_valid 0 and err_sticky 0. The next accepted beat is the first output.
- Parameter sweep: IMM_W=12, DATA_W=32, eop 011, imm 12'hFFF → 32'hFFFFFFFC.
